// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: turns a stream of ASCII bytes from a UART receiver into
// signed-direction magnitude commands of the form [+|-]digits<CR>, with error
// and drop pulses for malformed input and bytes arriving while a command waits.
module uart_cmd_sequencer #(
  parameter int MAX_DIGITS = 3
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic [7:0] i_Rx_Data,
  input  logic       i_Rx_Valid,
  input  logic       i_Cmd_Ready,
  output logic       o_Cmd_Valid,
  output logic [7:0] o_Value,
  output logic       o_Dir,
  output logic       o_Err,
  output logic       o_Drop
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SIGN,
    ST_DIGITS,
    ST_HOLD,
    ST_SKIP
  } state_t;

  typedef enum logic [2:0] {
    CL_DIGIT,
    CL_SPACE,
    CL_ENTER,
    CL_FWD,
    CL_BWD,
    CL_INVALID
  } class_t;

  state_t        state, state_next;
  logic [7:0]    acc, acc_next;
  logic [CW-1:0] count, count_next;
  logic          dir, dir_next;

  class_t        byte_class;
  logic [3:0]    digit;
  logic [9:0]    acc_wide;
  logic [9:0]    acc_new;
  logic          digit_reject;

  // Classify the incoming byte into the token kinds the grammar cares about.
  always_comb begin
    byte_class = CL_INVALID;
    digit      = i_Rx_Data[3:0];
    if (i_Rx_Data >= 8'h30 && i_Rx_Data <= 8'h39) begin
      byte_class = CL_DIGIT;
    end else begin
      case (i_Rx_Data)
        8'h20:   byte_class = CL_SPACE;
        8'h0D:   byte_class = CL_ENTER;
        8'h2B:   byte_class = CL_FWD;
        8'h2D:   byte_class = CL_BWD;
        default: byte_class = CL_INVALID;
      endcase
    end
  end

  // Next accumulator value acc*10+d at 10 bits; anything above 25 already
  // overflows 255 after the multiply, so it is rejected before the product
  // could wrap at 10 bits.
  always_comb begin
    acc_wide     = {2'b00, acc};
    acc_new      = (acc_wide << 3) + (acc_wide << 1) + {6'd0, digit};
    digit_reject = (count >= CW'(MAX_DIGITS)) || (acc > 8'd25) || (acc_new > 10'd255);
  end

  // Next-state and datapath decisions; each accepted byte advances the parser once.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    count_next = count;
    dir_next   = dir;

    case (state)
      ST_IDLE: begin
        if (i_Rx_Valid) begin
          case (byte_class)
            CL_DIGIT: begin
              state_next = ST_DIGITS;
              acc_next   = {4'd0, digit};
              count_next = CW'(1);
            end
            CL_FWD, CL_BWD: begin
              state_next = ST_SIGN;
              dir_next   = (byte_class == CL_BWD);
            end
            CL_INVALID: state_next = ST_SKIP;
            default:    state_next = ST_IDLE;
          endcase
        end
      end

      ST_SIGN: begin
        if (i_Rx_Valid) begin
          case (byte_class)
            CL_DIGIT: begin
              state_next = ST_DIGITS;
              acc_next   = {4'd0, digit};
              count_next = CW'(1);
            end
            CL_SPACE: state_next = ST_SIGN;
            default:  state_next = ST_SKIP;
          endcase
        end
      end

      ST_DIGITS: begin
        if (i_Rx_Valid) begin
          case (byte_class)
            CL_DIGIT: begin
              if (digit_reject) begin
                state_next = ST_SKIP;
              end else begin
                acc_next   = acc_new[7:0];
                count_next = count + CW'(1);
              end
            end
            CL_ENTER: state_next = ST_HOLD;
            CL_SPACE: state_next = ST_DIGITS;
            default:  state_next = ST_SKIP;
          endcase
        end
      end

      ST_HOLD: begin
        if (i_Cmd_Ready) begin
          state_next = ST_IDLE;
        end
      end

      ST_SKIP: begin
        if (i_Rx_Valid && byte_class == CL_ENTER) begin
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase

    if (state_next == ST_IDLE) begin
      acc_next   = 8'd0;
      count_next = '0;
      dir_next   = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Command accumulator, digit count and direction latch.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      acc   <= 8'd0;
      count <= '0;
      dir   <= 1'b0;
    end else begin
      acc   <= acc_next;
      count <= count_next;
      dir   <= dir_next;
    end
  end

  // Registered outputs: the command is captured on entry to HOLD and frozen until it is accepted.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Cmd_Valid <= 1'b0;
      o_Value     <= 8'd0;
      o_Dir       <= 1'b0;
      o_Err       <= 1'b0;
      o_Drop      <= 1'b0;
    end else begin
      o_Cmd_Valid <= (state_next == ST_HOLD);
      if (state != ST_HOLD && state_next == ST_HOLD) begin
        o_Value <= acc;
        o_Dir   <= dir;
      end else if (state_next != ST_HOLD) begin
        o_Value <= 8'd0;
        o_Dir   <= 1'b0;
      end
      o_Err  <= (state_next == ST_SKIP) && (state != ST_SKIP);
      o_Drop <= (state == ST_HOLD) && i_Rx_Valid;
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Testbench for uart_cmd_sequencer: a line-level grammar model predicts
// commands, error pulses and drop pulses; a monitor compares them against the DUT.
module tb_uart_cmd_sequencer;

  localparam int MAX_DIGITS = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [7:0] value;
  logic       dir;
  logic       err;
  logic       drop;

  always #5 clk = ~clk;

  uart_cmd_sequencer #(.MAX_DIGITS(MAX_DIGITS)) dut (
    .i_Clk       (clk),
    .i_Rst_n     (rst_n),
    .i_Rx_Data   (rx_data),
    .i_Rx_Valid  (rx_valid),
    .i_Cmd_Ready (cmd_ready),
    .o_Cmd_Valid (cmd_valid),
    .o_Value     (value),
    .o_Dir       (dir),
    .o_Err       (err),
    .o_Drop      (drop)
  );

  // Free-running cycle index used to time-stamp expected pulses.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         start;
    int         len;
    logic [7:0] value;
    logic       dir;
  } cmd_exp_t;

  cmd_exp_t cmd_q[$];
  int       err_q[$];
  int       drop_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  // ---------------- reference model: grammar over a whole line ----------------
  logic [7:0] line_q[$];
  bit         skipping = 1'b0;

  // True while the non-space bytes seen so far can still begin a legal command.
  function automatic bit line_ok(output int val, output bit d, output int ndig);
    int first;
    first = 0;
    val   = 0;
    d     = 1'b0;
    ndig  = 0;
    if (line_q.size() > 0 && (line_q[0] == "+" || line_q[0] == "-")) begin
      d     = (line_q[0] == "-");
      first = 1;
    end
    for (int i = first; i < line_q.size(); i++) begin
      if (line_q[i] < "0" || line_q[i] > "9") return 1'b0;
      val = val * 10 + (int'(line_q[i]) - 48);
      ndig++;
    end
    return (ndig <= MAX_DIGITS) && (val <= 255);
  endfunction

  // kind: 0 nothing, 1 command completed, 2 syntax/range error
  task automatic model_step(input logic [7:0] b, output int kind, output int val, output bit d);
    int nd;
    kind = 0;
    val  = 0;
    d    = 1'b0;
    if (skipping) begin
      if (b == 8'h0D) skipping = 1'b0;
    end else if (b == 8'h20) begin
      kind = 0;
    end else if (b == 8'h0D) begin
      if (line_q.size() != 0) begin
        if (line_ok(val, d, nd) && nd >= 1) begin
          kind = 1;
        end else begin
          kind     = 2;
          skipping = 1'b1;
        end
      end
      line_q.delete();
    end else begin
      line_q.push_back(b);
      if (!line_ok(val, d, nd)) begin
        kind     = 2;
        skipping = 1'b1;
        line_q.delete();
      end
    end
  endtask

  task automatic model_reset();
    line_q.delete();
    skipping = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int hold_k     = -1;
  int hold_junk  = -1;
  bit hold_abort = 1'b0;

  // Drive one valid byte; for a completed command also play out the HOLD handshake.
  task automatic apply_stimulus(input logic [7:0] b);
    int       kind;
    int       val;
    bit       d;
    int       k;
    cmd_exp_t e;
    @(negedge clk);
    rx_data   = b;
    rx_valid  = 1'b1;
    cmd_ready = 1'($urandom_range(0, 1));
    model_step(b, kind, val, d);
    if (kind == 2) err_q.push_back(cyc + 1);
    if (kind == 1) begin
      e.start = cyc + 1;
      e.value = val[7:0];
      e.dir   = d;
      if (hold_abort) begin
        cmd_ready = 1'b0;
        e.len     = -1;
        cmd_q.push_back(e);
      end else begin
        k     = (hold_k >= 0) ? hold_k : int'($urandom_range(0, 3));
        e.len = k + 1;
        cmd_q.push_back(e);
        for (int i = 0; i <= k; i++) begin
          @(negedge clk);
          cmd_ready = (i == k);
          rx_data   = 8'($urandom);
          rx_valid  = (hold_junk >= 0) ? hold_junk[i] : 1'($urandom_range(0, 1));
          if (rx_valid) drop_q.push_back(cyc + 1);
        end
      end
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) apply_stimulus(s[i]);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    rx_valid  = 1'b0;
    rx_data   = 8'($urandom);
    cmd_ready = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [7:0] random_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 55)      return 8'h30 + 8'($urandom_range(0, 9));
    else if (r < 63) return 8'h20;
    else if (r < 70) return 8'h2B;
    else if (r < 77) return 8'h2D;
    else if (r < 90) return 8'h0D;
    else             return 8'h41 + 8'($urandom_range(0, 25));
  endfunction

  task automatic check_all_zero(input string tag);
    check_output({tag, "_valid"}, cmd_valid, 0);
    check_output({tag, "_value"}, value, 0);
    check_output({tag, "_dir"}, dir, 0);
    check_output({tag, "_err"}, err, 0);
    check_output({tag, "_drop"}, drop, 0);
  endtask

  // Assert reset between clock edges and confirm outputs clear without waiting for an edge.
  task automatic pulse_reset_mid_cycle();
    @(negedge clk);
    rx_valid  = 1'b0;
    cmd_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit       in_cmd = 1'b0;
  int       seen   = 0;
  cmd_exp_t cur;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (err) begin
        if (err_q.size() == 0) check_output("unexpected_err", cyc, -1);
        else check_output("err_cycle", cyc, err_q.pop_front());
      end
      if (drop) begin
        if (drop_q.size() == 0) check_output("unexpected_drop", cyc, -1);
        else check_output("drop_cycle", cyc, drop_q.pop_front());
      end
      if (cmd_valid) begin
        if (!in_cmd) begin
          in_cmd = 1'b1;
          seen   = 0;
          if (cmd_q.size() == 0) begin
            check_output("unexpected_cmd", cyc, -1);
            cur = '{start: cyc, len: -1, value: 8'd0, dir: 1'b0};
          end else begin
            cur = cmd_q.pop_front();
            check_output("cmd_start", cyc, cur.start);
          end
        end
        seen++;
        check_output("cmd_value", value, cur.value);
        check_output("cmd_dir", dir, cur.dir);
      end else if (in_cmd) begin
        in_cmd = 1'b0;
        if (cur.len >= 0) check_output("cmd_len", seen, cur.len);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n     = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Basic forward command with the consumer already ready.
    hold_k = 0;
    send_str("123\015");

    // Backward command held for three not-ready cycles with one byte dropped.
    hold_k    = 3;
    hold_junk = 4'b0010;
    send_str("-42\015");
    hold_k    = -1;
    hold_junk = -1;

    // Range, syntax, digit-count errors and recovery.
    send_str("300\0157\015");
    send_str("1A5\0151234\015");
    send_str("\015+\015\015 9 \015");

    // Reset mid-command discards the partial value.
    send_str("5");
    pulse_reset_mid_cycle();
    send_str("6\015");

    // Reset while a command is being presented.
    send_str("5");
    hold_abort = 1'b1;
    send_str("\015");
    hold_abort = 1'b0;
    @(posedge clk);
    #1 check_output("pre_rst_valid", cmd_valid, 1);
    pulse_reset_mid_cycle();
    send_str("8\015");

    // Randomized byte stream with idle gaps.
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      apply_stimulus(random_byte());
    end
    send_str("\015\015");
    repeat (10) idle_cycle();

    check_output("cmd_q_left", cmd_q.size(), 0);
    check_output("err_q_left", err_q.size(), 0);
    check_output("drop_q_left", drop_q.size(), 0);
    check_output("cmd_open", in_cmd, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
